// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies one 256-byte CPU page into PPU OAM.
// Define OAM_DMA_ALIGN_EN to add the parity-driven ALIGN cycle (513/514-cycle transfers).
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned PAGE_BYTES   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_mem_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_write_en,
    output logic        cpu_halt,
    output logic [15:0] dma_mem_addr,
    output logic        dma_mem_read_en,
    input  logic [7:0]  dma_mem_data_in,
    output logic [7:0]  oam_index,
    output logic [7:0]  oam_data,
    output logic        oam_write_en,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
`ifdef OAM_DMA_ALIGN_EN
        ALIGN,
`endif
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        halt_q, halt_d;
    logic        read_en_q, read_en_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic        done_q, done_d;
`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q;
`endif

    // Next state plus next-cycle output decode so every output comes straight from a flop
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (cpu_write_en && (cpu_mem_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_data_out;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: state_d = READ;
`endif
            READ:  state_d = WRITE;
            WRITE: begin
                // idx wraps to 0 after the last byte; the page never carries
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase

        halt_d    = (state_d != IDLE);
        read_en_d = (state_d == READ);
        addr_d    = read_en_d ? {page_d, idx_d} : 16'd0;
        wr_en_d   = (state_d == WRITE);
        done_d    = (state_q == WRITE) && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            page_q    <= 8'd0;
            idx_q     <= 8'd0;
            halt_q    <= 1'b0;
            read_en_q <= 1'b0;
            addr_q    <= 16'd0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            halt_q    <= halt_d;
            read_en_q <= read_en_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    // Free-running cycle parity, independent of transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ~parity_q;
    end
`endif

    assign cpu_halt        = halt_q;
    assign dma_active      = halt_q;
    assign dma_mem_addr    = addr_q;
    assign dma_mem_read_en = read_en_q;
    assign oam_index       = idx_q;
    assign oam_write_en    = wr_en_q;
    assign dma_done        = done_q;
    // RAM data arrives during WRITE and passes straight through to OAM
    assign oam_data        = wr_en_q ? dma_mem_data_in : 8'd0;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma with a synchronous-read RAM model.
`timescale 1ns/1ps
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_mem_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic        cpu_halt;
    logic [15:0] dma_mem_addr;
    logic        dma_mem_read_en;
    logic [7:0]  dma_mem_data_in;
    logic [7:0]  oam_index;
    logic [7:0]  oam_data;
    logic        oam_write_en;
    logic        dma_active;
    logic        dma_done;

    int checks = 0;
    int errors = 0;

    oam_dma dut (
        .clk(clk), .rst(rst),
        .cpu_mem_addr(cpu_mem_addr), .cpu_data_out(cpu_data_out), .cpu_write_en(cpu_write_en),
        .cpu_halt(cpu_halt), .dma_mem_addr(dma_mem_addr), .dma_mem_read_en(dma_mem_read_en),
        .dma_mem_data_in(dma_mem_data_in), .oam_index(oam_index), .oam_data(oam_data),
        .oam_write_en(oam_write_en), .dma_active(dma_active), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    // RAM content: mem[a] = a[7:0] ^ 8'h59 ^ a[15:8], so page $03 holds i ^ 8'h5A
    logic [7:0] ram_q = 8'd0;
    always @(posedge clk)
        if (dma_mem_read_en) ram_q <= dma_mem_addr[7:0] ^ 8'h59 ^ dma_mem_addr[15:8];
    assign dma_mem_data_in = ram_q;

    // Cycle counter whose LSB tracks the free-running parity
    int cyc = 0;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // Observations from the last transfer
    int          halt_cnt, rd_cnt, wr_cnt, done_cnt, first_rd, rd_bad, wr_bad, done_c;
    logic [15:0] last_rd;
    logic        halt_at_done, halt_after_done, got_reset, timeout, hp;
    logic [7:0]  idx_at_done;
    logic [7:0]  rst_outs;

    task automatic do_transfer(input logic [7:0] page, input int spur_at, input int rst_after,
                               input int want_par, input bit chain);
        halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = -1;
        rd_bad = 0; wr_bad = 0; done_c = -1; last_rd = 16'd0;
        halt_at_done = 1'b1; halt_after_done = 1'b0; got_reset = 1'b0;
        timeout = 1'b1; idx_at_done = 8'hAA; rst_outs = 8'hFF;
        @(negedge clk);
        if (want_par >= 0 && cyc[0] == want_par[0]) @(negedge clk);
        cpu_mem_addr = 16'h4014; cpu_data_out = page; cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0; cpu_mem_addr = 16'h0000;
        hp = cyc[0];
        for (int c = 0; c < 700; c++) begin
            if (done_cnt == 0) begin
                if (cpu_halt) halt_cnt++;
                if (dma_mem_read_en) begin
                    if (first_rd < 0) first_rd = c;
                    if (dma_mem_addr !== {page, rd_cnt[7:0]}) rd_bad++;
                    last_rd = dma_mem_addr;
                    rd_cnt++;
                end
                if (oam_write_en) begin
                    if (oam_index !== wr_cnt[7:0] || oam_data !== (wr_cnt[7:0] ^ 8'h59 ^ page)) wr_bad++;
                    wr_cnt++;
                end
            end
            if (dma_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_c = c; halt_at_done = cpu_halt; idx_at_done = oam_index;
                end
            end
            if (done_c >= 0 && c == done_c + 1) halt_after_done = cpu_halt;
            if (done_c >= 0 && c >= done_c + 8) begin timeout = 1'b0; break; end
            cpu_write_en = 1'b0;
            if (c == spur_at) begin
                cpu_mem_addr = 16'h4014; cpu_data_out = 8'h07; cpu_write_en = 1'b1;
            end
            if (chain && dma_done) begin
                cpu_mem_addr = 16'h4014; cpu_data_out = 8'h05; cpu_write_en = 1'b1;
            end
            if (rst_after >= 0 && wr_cnt == rst_after) begin
                rst = 1'b1;
                #1;
                rst_outs = {cpu_halt, dma_active, dma_done, dma_mem_read_en, oam_write_en,
                            |dma_mem_addr, |oam_index, |oam_data};
                got_reset = 1'b1; timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        cpu_write_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_halt, dma_active, dma_done} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {cpu_halt, dma_active, dma_done});
        end
        checks++;
        if ({dma_mem_read_en, oam_write_en} !== 2'b00 || dma_mem_addr !== 16'd0) begin
            errors++; $display("FAIL reset_mem got re=%b we=%b addr=%h want 0", dma_mem_read_en, oam_write_en, dma_mem_addr);
        end
        checks++;
        if (oam_index !== 8'd0 || oam_data !== 8'd0) begin
            errors++; $display("FAIL reset_oam got idx=%h data=%h want 0", oam_index, oam_data);
        end
    endtask

    task automatic test_basic_copy();
        int exp_halt;
        do_transfer(8'h03, -1, -1, -1, 1'b0);
        exp_halt = ALIGN_ON ? 513 + int'(hp) : 513;
        checks++;
        if (timeout) begin errors++; $display("FAIL basic_timeout got no dma_done want done"); end
        checks++;
        if (wr_cnt != 256) begin errors++; $display("FAIL basic_writes got %0d want 256", wr_cnt); end
        checks++;
        if (wr_bad != 0) begin errors++; $display("FAIL basic_oam_data got %0d bad want 0", wr_bad); end
        checks++;
        if (rd_cnt != 256 || rd_bad != 0) begin
            errors++; $display("FAIL basic_reads got %0d reads %0d bad want 256 0", rd_cnt, rd_bad);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
        checks++;
        if (halt_cnt != exp_halt) begin errors++; $display("FAIL basic_halt got %0d want %0d", halt_cnt, exp_halt); end
        checks++;
        if (halt_at_done !== 1'b0) begin errors++; $display("FAIL basic_halt_at_done got %b want 0", halt_at_done); end
    endtask

    task automatic test_alignment();
        for (int p = 0; p < 2; p++) begin
            int exp_halt, exp_first;
            do_transfer(8'h01, -1, -1, p, 1'b0);
            exp_halt  = (ALIGN_ON && p == 1) ? 514 : 513;
            exp_first = (ALIGN_ON && p == 1) ? 2 : 1;
            checks++;
            if (hp !== p[0]) begin errors++; $display("FAIL align_parity got %b want %0d", hp, p); end
            checks++;
            if (halt_cnt != exp_halt) begin errors++; $display("FAIL align_halt_p%0d got %0d want %0d", p, halt_cnt, exp_halt); end
            checks++;
            if (first_rd != exp_first) begin errors++; $display("FAIL align_first_read_p%0d got %0d want %0d", p, first_rd, exp_first); end
        end
    endtask

    task automatic test_page_wrap();
        do_transfer(8'hFF, -1, -1, -1, 1'b0);
        checks++;
        if (last_rd !== 16'hFFFF) begin errors++; $display("FAIL wrap_last_addr got %h want FFFF", last_rd); end
        checks++;
        if (rd_bad != 0 || rd_cnt != 256) begin errors++; $display("FAIL wrap_reads got %0d bad of %0d want 0 of 256", rd_bad, rd_cnt); end
        checks++;
        if (idx_at_done !== 8'h00) begin errors++; $display("FAIL wrap_idx got %h want 00", idx_at_done); end
        checks++;
        if (wr_bad != 0) begin errors++; $display("FAIL wrap_oam_data got %0d bad want 0", wr_bad); end
    endtask

    task automatic test_spurious();
        do_transfer(8'h02, 50, -1, -1, 1'b0);
        checks++;
        if (rd_bad != 0 || rd_cnt != 256) begin errors++; $display("FAIL spur_reads got %0d bad of %0d want 0 of 256", rd_bad, rd_cnt); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL spur_done got %0d want 1", done_cnt); end
        checks++;
        if (wr_bad != 0 || wr_cnt != 256) begin errors++; $display("FAIL spur_writes got %0d bad of %0d want 0 of 256", wr_bad, wr_cnt); end
    endtask

    task automatic test_reset_mid();
        do_transfer(8'h06, -1, 100, -1, 1'b0);
        checks++;
        if (!got_reset) begin errors++; $display("FAIL rstmid_reached got %0d writes want 100", wr_cnt); end
        checks++;
        if (rst_outs !== 8'h00) begin errors++; $display("FAIL rstmid_outputs got %b want 00000000", rst_outs); end
        @(negedge clk);
        rst = 1'b0;
        do_transfer(8'h04, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt != 256 || wr_bad != 0) begin
            errors++; $display("FAIL rstmid_recopy got %0d writes %0d bad want 256 0", wr_cnt, wr_bad);
        end
    endtask

    task automatic test_non_trigger();
        int halt_seen = 0;
        int wr_seen = 0;
        @(negedge clk);
        cpu_mem_addr = 16'h4015; cpu_data_out = 8'h03; cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_mem_addr = 16'h2004;
        @(negedge clk);
        cpu_write_en = 1'b0; cpu_mem_addr = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            if (cpu_halt || dma_mem_read_en) halt_seen++;
            if (oam_write_en) wr_seen++;
            @(negedge clk);
        end
        checks++;
        if (halt_seen != 0) begin errors++; $display("FAIL nontrig_halt got %0d cycles want 0", halt_seen); end
        checks++;
        if (wr_seen != 0) begin errors++; $display("FAIL nontrig_writes got %0d want 0", wr_seen); end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        do_transfer(8'h03, -1, -1, -1, 1'b1);
        checks++;
        if (halt_after_done !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got halt=%b want 1", halt_after_done); end
        for (int c = 0; c < 600; c++) begin
            if (dma_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_second_done got none want 1"); end
    endtask

    initial begin
        rst = 1'b1; cpu_mem_addr = 16'h0000; cpu_data_out = 8'h00; cpu_write_en = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic_copy();
        test_alignment();
        test_page_wrap();
        test_spurious();
        test_reset_mid();
        test_non_trigger();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
